// File: rtl/counter_run_sched_pkg.sv
// complex_counter_pkg: shared definitions for the 3-bit mode-controlled
// complex counter and its run scheduler (counter_run_sched).
// Holds counter state names, mode encodings, the scheduler FSM encoding
// and the command record layout.
package complex_counter_pkg;

  // Counter state names (count values)
  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_F = 3'b101;
  localparam logic [2:0] ST_G = 3'b110;
  localparam logic [2:0] ST_H = 3'b111;

  // Counter mode encodings
  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_ALT = 1'b1;

  // Default field widths of a scheduler command
  localparam int CMD_STEP_W = 4;
  localparam int CMD_CNT_W  = 3;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  // Command record as presented by a requester
  typedef struct packed {
    logic                  mode;
    logic                  keep;
    logic [CMD_CNT_W-1:0]  target;
    logic [CMD_STEP_W-1:0] steps;
    logic                  id;
  } cmd_t;

endpackage

// File: rtl/counter_run_sched_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
// The pointer names the requester favoured when both request; a lone
// request is granted regardless. On the update strobe the pointer moves
// to the requester that was not granted. State changes on the falling edge.
module rr_arb2 (
  input  logic       clock,
  input  logic       nreset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr_r;

  // Grant decode from the requests and the round-robin pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer register: after a grant, favour the other requester
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      ptr_r <= 1'b0;
    end else if (update) begin
      ptr_r <= grant[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/counter_run_sched.sv
// counter_run_sched: schedules runs of the shared 3-bit complex counter
// for two requesters. Commands are taken over valid/ready, arbitrated
// round-robin, then the counter is cleared (unless keep) and stepped until
// the count equals the target or the step budget is spent.
// Optional feature macro: COUNTER_STALL_DETECT_EN - aborts a run when a
// step leaves the count unchanged (counter sitting on a self-loop state).
// All state updates on the falling edge of clock; nreset is async active-low.
module counter_run_sched
  import complex_counter_pkg::*;
#(
  parameter int STEP_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_mode,
  input  logic              req0_keep,
  input  logic [CNT_W-1:0]  req0_target,
  input  logic [STEP_W-1:0] req0_steps,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_mode,
  input  logic              req1_keep,
  input  logic [CNT_W-1:0]  req1_target,
  input  logic [STEP_W-1:0] req1_steps,
  input  logic [CNT_W-1:0]  cnt_count,
  output logic              cnt_mode,
  output logic              cnt_clear,
  output logic              cnt_step,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              done_hit,
  output logic              done_stall,
  output logic [CNT_W-1:0]  done_count
);

  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

  sched_state_t      state_r, state_s;
  logic              mode_r;
  logic [CNT_W-1:0]  target_r;
  logic [STEP_W-1:0] remaining_r;
  logic              id_r;
  logic              done_id_r;
  logic              done_hit_r;
  logic [CNT_W-1:0]  done_count_r;

  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  logic              hs_s;
  logic              sel_s;
  logic              sel_mode_s;
  logic              sel_keep_s;
  logic [CNT_W-1:0]  sel_target_s;
  logic [STEP_W-1:0] sel_steps_s;
  logic              hit_s;
  logic              stall_s;
  logic              empty_s;
  logic              step_s;
  logic              fin_s;

  // Requests only compete while idle; ready is forced low during reset
  assign req_s      = (state_r == S_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign req0_ready = grant_s[0] & nreset;
  assign req1_ready = grant_s[1] & nreset;
  assign hs_s       = grant_s[0] | grant_s[1];
  assign sel_s      = grant_s[1];

  rr_arb2 u_arb (
    .clock  (clock),
    .nreset (nreset),
    .req    (req_s),
    .update (hs_s),
    .grant  (grant_s)
  );

  // Select the command fields of the granted requester
  always_comb begin
    if (sel_s) begin
      sel_mode_s   = req1_mode;
      sel_keep_s   = req1_keep;
      sel_target_s = req1_target;
      sel_steps_s  = req1_steps;
    end else begin
      sel_mode_s   = req0_mode;
      sel_keep_s   = req0_keep;
      sel_target_s = req0_target;
      sel_steps_s  = req0_steps;
    end
  end

  assign hit_s   = (cnt_count == target_r);
  assign empty_s = (remaining_r == STEP_ZERO);

`ifdef COUNTER_STALL_DETECT_EN
  logic [CNT_W-1:0] prev_count_r;
  logic             stepped_r;
  logic             done_stall_r;

  // Remember the count each step started from, and whether last cycle stepped
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      prev_count_r <= {CNT_W{1'b0}};
      stepped_r    <= 1'b0;
    end else begin
      stepped_r <= step_s;
      if (step_s) begin
        prev_count_r <= cnt_count;
      end else begin
        prev_count_r <= prev_count_r;
      end
    end
  end

  assign stall_s = stepped_r & (cnt_count == prev_count_r);

  // Stall flag of the completed run; hit takes precedence over stall
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      done_stall_r <= 1'b0;
    end else if (fin_s) begin
      done_stall_r <= ~hit_s & stall_s;
    end else begin
      done_stall_r <= done_stall_r;
    end
  end

  assign done_stall = done_stall_r;
`else
  assign stall_s    = 1'b0;
  assign done_stall = 1'b0;
`endif

  // Next-state and step decision; the terminating RUN cycle issues no step
  always_comb begin
    state_s = state_r;
    step_s  = 1'b0;
    fin_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (hs_s) begin
          state_s = sel_keep_s ? S_RUN : S_CLEAR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: state_s = S_RUN;
      S_RUN: begin
        if (hit_s || stall_s || empty_s) begin
          state_s = S_DONE;
          fin_s   = 1'b1;
        end else begin
          step_s  = 1'b1;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM, command register, step budget and completion record
  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r      <= S_IDLE;
      mode_r       <= MODE_SEQ;
      target_r     <= {CNT_W{1'b0}};
      remaining_r  <= STEP_ZERO;
      id_r         <= 1'b0;
      done_id_r    <= 1'b0;
      done_hit_r   <= 1'b0;
      done_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (hs_s) begin
        mode_r      <= sel_mode_s;
        target_r    <= sel_target_s;
        remaining_r <= sel_steps_s;
        id_r        <= sel_s;
      end else if (step_s) begin
        remaining_r <= remaining_r - STEP_ONE;
      end else begin
        remaining_r <= remaining_r;
      end
      if (fin_s) begin
        done_id_r    <= id_r;
        done_hit_r   <= hit_s;
        done_count_r <= cnt_count;
      end else begin
        done_id_r    <= done_id_r;
        done_hit_r   <= done_hit_r;
        done_count_r <= done_count_r;
      end
    end
  end

  assign cnt_mode   = mode_r;
  assign cnt_clear  = (state_r == S_CLEAR);
  assign cnt_step   = step_s;
  assign busy       = (state_r == S_CLEAR) || (state_r == S_RUN);
  assign done       = (state_r == S_DONE);
  assign done_id    = done_id_r;
  assign done_hit   = done_hit_r;
  assign done_count = done_count_r;

endmodule

// File: tb/tb_counter_run_sched.sv
// tb_counter_run_sched: self-checking bench for counter_run_sched.
// A behavioural model of the complex counter is attached to the cnt_* port;
// expected run outcomes come from a step-by-step run predictor.
module tb_counter_run_sched;

`ifdef COUNTER_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       nreset;
  logic       req0_valid, req0_ready, req0_mode, req0_keep;
  logic [2:0] req0_target;
  logic [3:0] req0_steps;
  logic       req1_valid, req1_ready, req1_mode, req1_keep;
  logic [2:0] req1_target;
  logic [3:0] req1_steps;
  logic [2:0] cnt = 3'd0;
  logic       cnt_mode, cnt_clear, cnt_step;
  logic       busy, done, done_id, done_hit, done_stall;
  logic [2:0] done_count;

  int checks = 0;
  int errors = 0;

  counter_run_sched dut (
    .clock(clock), .nreset(nreset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_keep(req0_keep), .req0_target(req0_target), .req0_steps(req0_steps),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_keep(req1_keep), .req1_target(req1_target), .req1_steps(req1_steps),
    .cnt_count(cnt), .cnt_mode(cnt_mode), .cnt_clear(cnt_clear), .cnt_step(cnt_step),
    .busy(busy), .done(done), .done_id(done_id), .done_hit(done_hit),
    .done_stall(done_stall), .done_count(done_count)
  );

  always #5 clock = ~clock;

  // Counter model: sequential mode counts up; alternate mode follows a table
  // with a single self-loop at 0 (and 2->6->7, 5->6->7).
  function automatic logic [2:0] next_cnt(input logic m, input logic [2:0] c);
    if (!m) return c + 3'd1;
    case (c)
      3'd0: return 3'd0;
      3'd1: return 3'd3;
      3'd2: return 3'd6;
      3'd3: return 3'd5;
      3'd4: return 3'd1;
      3'd5: return 3'd6;
      3'd6: return 3'd7;
      default: return 3'd4;
    endcase
  endfunction

  // The counter reacts to clear/step on the falling edge; it has no reset
  always @(negedge clock) begin
    if (cnt_clear) cnt <= 3'd0;
    else if (cnt_step) cnt <= next_cnt(cnt_mode, cnt);
  end

  // Run predictor: walk the counter until target, fixed point, or budget end
  function automatic void predict(input logic [2:0] start, input logic keep, input logic mode,
                                  input logic [2:0] target, input logic [3:0] steps,
                                  output logic hit, output logic stall,
                                  output logic [2:0] fin, output int nsteps);
    logic [2:0] c;
    int rem;
    bit fixed;
    c = keep ? start : 3'd0;
    rem = int'(steps);
    nsteps = 0; hit = 1'b0; stall = 1'b0; fixed = 1'b0;
    for (int g = 0; g < 64; g++) begin
      if (c == target) begin hit = 1'b1; break; end
      if (STALL_EN && fixed) begin stall = 1'b1; break; end
      if (rem == 0) break;
      fixed = (next_cnt(mode, c) == c);
      c = next_cnt(mode, c);
      rem--; nsteps++;
    end
    fin = c;
  endfunction

  // Issue one command from requester id and check its complete run
  task automatic run_cmd(input logic id, input logic mode, input logic keep,
                         input logic [2:0] target, input logic [3:0] steps, input string tag);
    logic [2:0] exp_cnt;
    logic exp_hit, exp_stall;
    int exp_n, exp_lat, lat, nstep, nclear;
    bit seen, got;
    if (id == 1'b0) begin
      req0_mode = mode; req0_keep = keep; req0_target = target; req0_steps = steps; req0_valid = 1'b1;
    end else begin
      req1_mode = mode; req1_keep = keep; req1_target = target; req1_steps = steps; req1_valid = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if ((id == 1'b0) ? req0_ready : req1_ready) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s handshake: ready never seen, required within 40 cycles", tag);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    predict(cnt, keep, mode, target, steps, exp_hit, exp_stall, exp_cnt, exp_n);
    exp_lat = (keep ? 2 : 3) + exp_n;
    @(negedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0; nstep = 0; nclear = 0; got = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if (cnt_step) nstep++;
      if (cnt_clear) nclear++;
      if (done) begin lat = i; got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done: no done pulse within 60 cycles", tag);
      return;
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat); end
    checks++;
    if (done_hit !== exp_hit) begin errors++; $display("FAIL %s done_hit: got %b required %b", tag, done_hit, exp_hit); end
    checks++;
    if (done_stall !== exp_stall) begin errors++; $display("FAIL %s done_stall: got %b required %b", tag, done_stall, exp_stall); end
    checks++;
    if (done_count !== exp_cnt) begin errors++; $display("FAIL %s done_count: got %0d required %0d", tag, done_count, exp_cnt); end
    checks++;
    if (done_id !== id) begin errors++; $display("FAIL %s done_id: got %b required %b", tag, done_id, id); end
    checks++;
    if (nstep != exp_n) begin errors++; $display("FAIL %s step pulses: got %0d required %0d", tag, nstep, exp_n); end
    checks++;
    if (nclear != (keep ? 0 : 1)) begin errors++; $display("FAIL %s clear pulses: got %0d required %0d", tag, nclear, keep ? 0 : 1); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy in done: got %b required 0", tag, busy); end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done width: got %b one cycle later, required 0", tag, done); end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({busy, done, cnt_step, cnt_clear, cnt_mode, req0_ready, req1_ready} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, done, cnt_step, cnt_clear, cnt_mode, req0_ready, req1_ready});
    end
    checks++;
    if ({done_id, done_hit, done_stall, done_count} !== 6'd0) begin
      errors++;
      $display("FAIL reset_done: got %b required 000000", {done_id, done_hit, done_stall, done_count});
    end
    @(posedge clock); #1;
    nreset = 1'b1;
  endtask

  task automatic test_directed();
    run_cmd(1'b0, 1'b0, 1'b0, 3'd5, 4'd15, "seq_t5");
    run_cmd(1'b1, 1'b1, 1'b1, 3'd7, 4'd4, "alt_keep_t7");
    run_cmd(1'b0, 1'b1, 1'b0, 3'd7, 4'd4, "alt_selfloop");
    run_cmd(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, "steps0_hit");
    run_cmd(1'b0, 1'b0, 1'b0, 3'd3, 4'd0, "steps0_miss");
  endtask

  // Both requesters hold valid from reset: grants must alternate 0,1,0
  task automatic test_arbitration();
    logic exp_ptr;
    int grants;
    bit got;
    nreset = 1'b0;
    req0_mode = 1'b0; req0_keep = 1'b0; req0_target = 3'd1; req0_steps = 4'd3;
    req1_mode = 1'b0; req1_keep = 1'b0; req1_target = 3'd1; req1_steps = 4'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clock); #1;
    nreset = 1'b1;
    exp_ptr = 1'b0; grants = 0;
    for (int i = 0; i < 80 && grants < 3; i++) begin
      #1;
      checks++;
      if (req0_ready && req1_ready) begin errors++; $display("FAIL arb_onehot: both ready high at cycle %0d", i); end
      if (req0_ready || req1_ready) begin
        checks++;
        if (req1_ready !== exp_ptr) begin
          errors++;
          $display("FAIL arb_order grant %0d: got req%0d required req%0d", grants, req1_ready, exp_ptr);
        end
        exp_ptr = ~req1_ready;
        grants++;
        if (grants == 3) begin @(negedge clock); #1; req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      @(posedge clock); #1;
    end
    checks++;
    if (grants != 3) begin errors++; $display("FAIL arb_count: got %0d grants required 3", grants); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1;
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL arb_done: last run gave no done within 40 cycles"); end
    checks++;
    if (done_id !== 1'b0) begin errors++; $display("FAIL arb_last_id: got %b required 0", done_id); end
    @(posedge clock); #1;
  endtask

  // Reset in the middle of a run, with req0 still requesting
  task automatic test_reset_midrun();
    bit seen;
    req0_mode = 1'b0; req0_keep = 1'b0; req0_target = 3'd7; req0_steps = 4'd15; req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (req0_ready) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrun_handshake: ready never seen"); end
    @(negedge clock); #1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || cnt_step !== 1'b1) begin
      errors++; $display("FAIL midrun_running: busy=%b step=%b required 1 1", busy, cnt_step);
    end
    #2; nreset = 1'b0; #1;
    checks++;
    if ({busy, done, cnt_step, cnt_clear, cnt_mode, req0_ready, req1_ready} !== 7'd0) begin
      errors++;
      $display("FAIL midrun_async_reset: got %b required 0000000",
               {busy, done, cnt_step, cnt_clear, cnt_mode, req0_ready, req1_ready});
    end
    @(negedge clock); #1;
    checks++;
    if ({busy, cnt_step, req0_ready} !== 3'd0) begin
      errors++; $display("FAIL midrun_held_reset: got %b required 000", {busy, cnt_step, req0_ready});
    end
    @(posedge clock); #1;
    nreset = 1'b1;
    run_cmd(1'b0, 1'b0, 1'b0, 3'd7, 4'd15, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    nreset = 1'b0;
    req0_valid = 1'b0; req0_mode = 1'b0; req0_keep = 1'b0; req0_target = 3'd0; req0_steps = 4'd0;
    req1_valid = 1'b0; req1_mode = 1'b0; req1_keep = 1'b0; req1_target = 3'd0; req1_steps = 4'd0;
    test_reset();
    test_directed();
    test_arbitration();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
